// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate generator with a 2-entry skid buffer
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [3:0] F_NONE    = 4'd0;
  localparam logic [3:0] F_I       = 4'd1;
  localparam logic [3:0] F_IL      = 4'd2;
  localparam logic [3:0] F_S       = 4'd3;
  localparam logic [3:0] F_B       = 4'd4;
  localparam logic [3:0] F_U_LUI   = 4'd5;
  localparam logic [3:0] F_U_AUIPC = 4'd6;
  localparam logic [3:0] F_J       = 4'd7;
  localparam logic [3:0] F_JALR    = 4'd8;
  localparam logic [3:0] F_SHAMT   = 4'd9;
  localparam logic [3:0] F_CSR_Z   = 4'd10;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [3:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t        dec;
  ent_t        m_q;
  ent_t        k_q;
  logic        m_valid;
  logic        k_valid;
  logic [31:0] raw;
  logic        sext;

  // Immediates are assembled in 32 bits, then sign- or zero-extended to XLEN.
  always_comb begin
    raw         = '0;
    sext        = 1'b0;
    dec.fmt     = F_NONE;
    dec.illegal = 1'b0;
    dec.tag     = in_tag;
    case (in_instr[6:0])
      7'b0110011: dec.fmt = F_NONE;
      7'b0010011: begin
        if (in_instr[13:12] == 2'b01) begin
          dec.fmt  = F_SHAMT;
          raw[4:0] = in_instr[24:20];
          if (XLEN == 64) raw[5] = in_instr[25];
        end else begin
          dec.fmt = F_I;
          sext    = 1'b1;
          raw     = {20'b0, in_instr[31:20]};
        end
      end
      7'b0000011: begin
        dec.fmt = F_IL;
        sext    = 1'b1;
        raw     = {20'b0, in_instr[31:20]};
      end
      7'b0100011: begin
        dec.fmt = F_S;
        sext    = 1'b1;
        raw     = {20'b0, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec.fmt = F_B;
        sext    = 1'b1;
        raw     = {19'b0, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = in_instr[5] ? F_U_LUI : F_U_AUIPC;
        sext    = 1'b1;
        raw     = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = F_J;
        sext    = 1'b1;
        raw     = {11'b0, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b1100111: begin
        dec.fmt = F_JALR;
        sext    = 1'b1;
        raw     = {20'b0, in_instr[31:20]};
      end
      7'b1110011: begin
        if (in_instr[14]) begin
          dec.fmt = F_CSR_Z;
          raw     = {27'b0, in_instr[19:15]};
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Short-width fields need their sign bit moved to bit 31 before the final extension.
  logic [31:0] raw_sx;
  always_comb begin
    raw_sx = raw;
    if (sext) begin
      case (dec.fmt)
        F_I, F_IL, F_S, F_JALR: raw_sx = {{20{raw[11]}}, raw[11:0]};
        F_B:                    raw_sx = {{19{raw[12]}}, raw[12:0]};
        F_J:                    raw_sx = {{11{raw[20]}}, raw[20:0]};
        default:                raw_sx = raw;
      endcase
    end
  end

  assign dec.imm = sext ? XLEN'($signed(raw_sx)) : XLEN'(raw);

  // K can only fill while M is stalled, and a full K blocks input, so M never sees both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
      m_q     <= '0;
      k_q     <= '0;
    end else if (!m_valid || out_ready) begin
      if (k_valid) begin
        m_q     <= k_q;
        m_valid <= 1'b1;
        k_valid <= 1'b0;
      end else if (in_valid) begin
        m_q     <= dec;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (in_valid && !k_valid) begin
      k_q     <= dec;
      k_valid <= 1'b1;
    end
  end

  assign in_ready    = !k_valid;
  assign out_valid   = m_valid;
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.illegal;
  assign out_tag     = m_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        v32, rdy32, ill32, v64, rdy64, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic [3:0]  fmt32, fmt64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sb_ins[$];
  logic [31:0] sb_tag[$];
  logic [31:0] emitted[$];

  logic        s_valid, s_inrdy, s_ill, acc, stall_prev;
  logic [31:0] s_imm32, s_tag;
  logic [63:0] s_imm64;
  logic [3:0]  s_fmt;
  logic [63:0] h_imm;
  logic [31:0] h_tag;
  logic [3:0]  h_fmt;

  logic [31:0] seq_i[4] = '{32'hFE112E23, 32'hFF9FF06F, 32'h00309093, 32'h3002D073};
  logic [31:0] seq_m[4] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000003, 32'h00000005};
  logic [3:0]  seq_f[4] = '{4'd3, 4'd7, 4'd9, 4'd10};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode: immediates as signed integers, scaled arithmetically, then cut to XLEN.
  function automatic void ref_dec(input logic [31:0] ins, input int xl,
                                  output logic [63:0] imm, output logic [3:0] fmt,
                                  output logic ill);
    longint v = 0;
    fmt = 4'd0;
    ill = 1'b0;
    case (ins[6:0])
      7'b0110011: fmt = 4'd0;
      7'b0010011:
        if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) begin
          fmt = 4'd9;
          v = (xl == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
        end else begin
          fmt = 4'd1;
          v = longint'($signed(ins[31:20]));
        end
      7'b0000011: begin fmt = 4'd2; v = longint'($signed(ins[31:20])); end
      7'b0100011: begin fmt = 4'd3; v = longint'($signed({ins[31:25], ins[11:7]})); end
      7'b1100011: begin
        fmt = 4'd4;
        v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
      end
      7'b0110111: begin fmt = 4'd5; v = longint'($signed(ins[31:12])) * 4096; end
      7'b0010111: begin fmt = 4'd6; v = longint'($signed(ins[31:12])) * 4096; end
      7'b1101111: begin
        fmt = 4'd7;
        v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
      end
      7'b1100111: begin fmt = 4'd8; v = longint'($signed(ins[31:20])); end
      7'b1110011:
        if (ins[14]) begin fmt = 4'd10; v = longint'(ins[19:15]); end
      default: ill = 1'b1;
    endcase
    imm = (xl == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom();
    case ($urandom_range(0, 11))
      0:  r[6:0] = 7'b0110011;
      1:  r[6:0] = 7'b0010011;
      2:  r[6:0] = 7'b0000011;
      3:  r[6:0] = 7'b0100011;
      4:  r[6:0] = 7'b1100011;
      5:  r[6:0] = 7'b0110111;
      6:  r[6:0] = 7'b0010111;
      7:  r[6:0] = 7'b1101111;
      8:  r[6:0] = 7'b1100111;
      9:  r[6:0] = 7'b1110011;
      10: r[6:0] = 7'b0010011;
      default: ;
    endcase
    return r;
  endfunction

  // One clock: sample at negedge, score handshakes, return at posedge+1 for new drives.
  task automatic step();
    logic [63:0] ri32, ri64;
    logic [3:0]  rf;
    logic        rl;
    logic [31:0] ei, et;
    @(negedge clk);
    s_valid = v32;  s_inrdy = rdy32; s_imm32 = imm32; s_imm64 = imm64;
    s_fmt = fmt32;  s_ill = ill32;   s_tag = tag32;
    acc = in_valid && rdy32;
    if (stall_prev) begin
      chk("hold_valid", s_valid, 1);
      chk("hold_imm", s_imm64, h_imm);
      chk("hold_fmt", s_fmt, h_fmt);
      chk("hold_tag", s_tag, h_tag);
    end
    stall_prev = s_valid && !out_ready;
    h_imm = s_imm64; h_fmt = s_fmt; h_tag = s_tag;
    if (s_valid && out_ready) begin
      chk("sb_nonempty", sb_ins.size() != 0, 1);
      if (sb_ins.size() != 0) begin
        ei = sb_ins.pop_front();
        et = sb_tag.pop_front();
        ref_dec(ei, 32, ri32, rf, rl);
        chk("imm32", s_imm32, ri32);
        chk("fmt32", s_fmt, rf);
        chk("ill32", s_ill, rl);
        chk("tag32", s_tag, et);
        ref_dec(ei, 64, ri64, rf, rl);
        chk("imm64", imm64, ri64);
        chk("fmt64", fmt64, rf);
        chk("ill64", ill64, rl);
        chk("tag64", tag64, et);
      end
      emitted.push_back(s_tag);
    end
    if (acc) begin
      sb_ins.push_back(in_instr);
      sb_tag.push_back(in_tag);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
    stall_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", v32, 0);
    chk("rst_ready", rdy32, 1);
    chk("rst_imm32", imm32, 0);
    chk("rst_imm64", imm64, 0);
    chk("rst_fmt", fmt32, 0);
    chk("rst_ill", ill32, 0);
    chk("rst_tag", tag32, 0);
    reset = 1'b0;
    step();

    // addi x1, x0, -1
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'h100;
    step();
    chk("addi_acc", acc, 1);
    in_valid = 1'b0;
    step();
    chk("addi_valid", s_valid, 1);
    chk("addi_imm", s_imm32, 32'hFFFFFFFF);
    chk("addi_fmt", s_fmt, 1);
    chk("addi_ill", s_ill, 0);

    // back-to-back sw/jal/slli/csrrwi
    for (int k = 0; k <= 4; k++) begin
      in_valid = (k < 4);
      if (k < 4) begin in_instr = seq_i[k]; in_tag = 32'h200 + k; end
      step();
      if (k > 0) begin
        chk("seq_valid", s_valid, 1);
        chk("seq_imm", s_imm32, seq_m[k-1]);
        chk("seq_fmt", s_fmt, seq_f[k-1]);
        chk("seq_ready", s_inrdy, 1);
      end
    end

    in_valid = 1'b1; in_instr = 32'h800002B7; in_tag = 32'h300;
    step();
    in_valid = 1'b0;
    step();
    chk("lui_imm64", s_imm64, 64'hFFFFFFFF80000000);
    chk("lui_imm32", s_imm32, 32'h80000000);
    chk("lui_fmt", fmt64, 5);

    in_valid = 1'b1; in_instr = 32'h0000007F; in_tag = 32'h400;
    step();
    in_valid = 1'b0;
    step();
    chk("illeg_flag", s_ill, 1);
    chk("illeg_imm", s_imm64, 0);
    chk("illeg_fmt", s_fmt, 0);

    // back-pressure with tags 1,2,3
    emitted.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    in_tag = 1; in_instr = rand_instr();
    step();
    chk("bp_rdy1", s_inrdy, 1);
    in_tag = 2; in_instr = rand_instr();
    step();
    chk("bp_rdy2", s_inrdy, 1);
    in_tag = 3; in_instr = rand_instr();
    step();
    chk("bp_rdy3", s_inrdy, 0);
    chk("bp_head", s_tag, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && emitted.size() < 3; i++) begin
      step();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_count", emitted.size(), 3);
    for (int i = 0; i < 3 && i < emitted.size(); i++) chk("bp_order", emitted[i], i + 1);
    in_valid = 1'b0;
    step();

    // reset while K holds an entry
    out_ready = 1'b0; in_valid = 1'b1;
    in_tag = 10; in_instr = rand_instr();
    step();
    in_tag = 11; in_instr = rand_instr();
    step();
    in_valid = 1'b0;
    chk("prerst_ready", rdy32, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid32", v32, 0);
    chk("arst_ready32", rdy32, 1);
    chk("arst_valid64", v64, 0);
    chk("arst_ready64", rdy64, 1);
    sb_ins.delete(); sb_tag.delete(); stall_prev = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_valid", s_valid, 0);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_tag    = $urandom();
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb_ins.size() != 0 || v32); i++) step();
    chk("drain_empty", sb_ins.size(), 0);
    chk("drain_idle", v32, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
